fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle datapath; owns the PC register and the instruction register.
- Drives imm = instr[15:0] into the sign-extension stage and consumes its 32-bit sign-extended output (simm) to form branch targets.
- Talks to instruction memory over a req/ack handshake and presents a held, valid instruction to decode until decode releases it.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and instruction registers.
// Fetches from instruction memory over a req/ack handshake, holds the
// fetched word for decode until released, then advances the PC.
// The advance is sequential, a taken branch, or a J-type jump.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_take,
    input  logic [31:0] simm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [15:0] imm,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] simm_x4;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;
    logic [31:0] next_pc;

    // Simple views of the held state; valid in every state, including reset.
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign imm       = instr[15:0];

    // The shift drops simm[31:30]; the branch add wraps modulo 2^32.
    assign simm_x4       = simm << 2;
    assign branch_target = pc_plus4 + simm_x4;
    assign jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};

    // Select the address of the next instruction: jump beats branch beats sequential.
    always_comb begin
        // NOTE: a default assignment first means every path drives next_pc, so no latch is inferred.
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_addr;
        end else if (branch_take) begin
            next_pc = branch_target;
        end
    end

    // Fetch FSM with registered outputs: request, capture, hold, and advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            instr_count <= 32'd0;
            imem_req    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register update from the same pre-edge values.
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    // rdata is only meaningful on the ack edge; otherwise keep waiting.
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    // While decode stalls, branch/jump/ack are all ignored.
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + 32'd1;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expected values.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_take;
    logic [31:0] simm;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] imm;
    logic [31:0] instr_count;

    int          n_compared;
    int          n_mismatched;
    logic [31:0] exp_count;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .branch_take (branch_take),
        .simm        (simm),
        .jump        (jump),
        .jump_target (jump_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .imm         (imm),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // In FETCH at exp_addr: hold ack low for 'delay' cycles, then ack with 'word'.
    task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] word, input int delay);
        check({tag, ".req"}, {31'd0, imem_req}, 32'd1);
        check({tag, ".addr"}, imem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hBAD0_0000 | i;
            tick();
            check({tag, ".wait_req"}, {31'd0, imem_req}, 32'd1);
            check({tag, ".wait_addr"}, imem_addr, exp_addr);
            check({tag, ".wait_valid"}, {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD1_1111;
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, ".instr"}, instr, word);
        check({tag, ".imm"}, {16'd0, imm}, {16'd0, word[15:0]});
        check({tag, ".req_off"}, {31'd0, imem_req}, 32'd0);
        check({tag, ".pc"}, pc, exp_addr);
    endtask

    // In VALID: release with the given control inputs and check the new pc.
    task automatic do_release(input string tag, input logic j, input logic b,
                              input logic [25:0] jt, input logic [31:0] s,
                              input logic [31:0] exp_pc);
        jump        = j;
        branch_take = b;
        jump_target = jt;
        simm        = s;
        stall       = 1'b0;
        tick();
        stall       = 1'b1;
        jump        = 1'b0;
        branch_take = 1'b0;
        exp_count   = exp_count + 32'd1;
        check({tag, ".next_pc"}, pc, exp_pc);
        check({tag, ".pc_plus4"}, pc_plus4, exp_pc + 32'd4);
        check({tag, ".count"}, instr_count, exp_count);
        check({tag, ".valid_off"}, {31'd0, instr_valid}, 32'd0);
        check({tag, ".req_on"}, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        exp_count    = 32'd0;
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        stall        = 1'b1;
        branch_take  = 1'b0;
        simm         = 32'd0;
        jump         = 1'b0;
        jump_target  = 26'd0;

        // Reset state.
        #2;
        check("rst.pc", pc, 32'h0000_0000);
        check("rst.addr", imem_addr, 32'h0000_0000);
        check("rst.req", {31'd0, imem_req}, 32'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.valid", {31'd0, instr_valid}, 32'd0);
        check("rst.count", instr_count, 32'd0);
        check("rst.pc_plus4", pc_plus4, 32'h0000_0004);
        tick();
        rst_n = 1'b1;
        tick();

        // 1. First fetch, ack in the request cycle.
        do_fetch("t1", 32'h0000_0000, 32'h2008_0005, 0);
        check("t1.imm_val", {16'd0, imm}, 32'h0000_0005);
        do_release("t1", 1'b0, 1'b0, 26'd0, 32'd0, 32'h0000_0004);

        // Walk sequentially to 0x10.
        do_fetch("seq4", 32'h0000_0004, 32'h0000_0004, 0);
        do_release("seq4", 1'b0, 1'b0, 26'd0, 32'd0, 32'h0000_0008);
        do_fetch("seq8", 32'h0000_0008, 32'h0000_0008, 0);
        do_release("seq8", 1'b0, 1'b0, 26'd0, 32'd0, 32'h0000_000C);
        do_fetch("seqc", 32'h0000_000C, 32'h0000_000C, 0);
        do_release("seqc", 1'b0, 1'b0, 26'd0, 32'd0, 32'h0000_0010);

        // 2. Backward branch: 0x14 - 16 = 0x04.
        do_fetch("t2a", 32'h0000_0010, 32'h1000_FFFF, 0);
        do_release("t2a", 1'b0, 1'b1, 26'd0, 32'hFFFF_FFFC, 32'h0000_0004);
        // Back to 0x10: 0x08 + 8.
        do_fetch("t2b", 32'h0000_0004, 32'h1000_0002, 0);
        do_release("t2b", 1'b0, 1'b1, 26'd0, 32'h0000_0002, 32'h0000_0010);
        // Forward branch: 0x14 + 12 = 0x20.
        do_fetch("t2c", 32'h0000_0010, 32'h1000_0003, 0);
        do_release("t2c", 1'b0, 1'b1, 26'd0, 32'h0000_0003, 32'h0000_0020);
        // Long branch: 0x24 + 0x0FFF_FFFC = 0x1000_0020.
        do_fetch("t2d", 32'h0000_0020, 32'h1000_0004, 0);
        do_release("t2d", 1'b0, 1'b1, 26'd0, 32'h03FF_FFFF, 32'h1000_0020);

        // 3. Jump and branch together: jump wins -> 0x1000_0100.
        do_fetch("t3", 32'h1000_0020, 32'h0800_0040, 0);
        do_release("t3", 1'b1, 1'b1, 26'h000_0040, 32'h0000_0100, 32'h1000_0100);

        // 4. Stall five cycles with branch_take toggling and a stray ack.
        do_fetch("t4", 32'h1000_0100, 32'hCAFE_1234, 0);
        simm = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            branch_take = i[0];
            imem_ack    = 1'b1;
            imem_rdata  = 32'h5555_0000 | i;
            tick();
            check("t4.instr", instr, 32'hCAFE_1234);
            check("t4.pc", pc, 32'h1000_0100);
            check("t4.valid", {31'd0, instr_valid}, 32'd1);
            check("t4.count", instr_count, exp_count);
            check("t4.req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;
        do_release("t4", 1'b0, 1'b0, 26'd0, 32'd0, 32'h1000_0104);

        // 5. Ack delayed three cycles.
        do_fetch("t5a", 32'h1000_0104, 32'hA5A5_5A5A, 3);
        // Branch to 0xFFFF_FFFC; simm[31:30] must not affect the target.
        do_release("t5a", 1'b0, 1'b1, 26'd0, 32'hFBFF_FFBD, 32'hFFFF_FFFC);
        do_fetch("t5b", 32'hFFFF_FFFC, 32'h0000_0000, 0);
        check("t5b.pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        do_release("t5b", 1'b0, 1'b0, 26'd0, 32'd0, 32'h0000_0000);

        // 6. Reset while waiting for an ack at pc 0x4.
        do_fetch("t6a", 32'h0000_0000, 32'h1111_2222, 0);
        do_release("t6a", 1'b0, 1'b0, 26'd0, 32'd0, 32'h0000_0004);
        tick();
        check("t6.wait_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.rst_req", {31'd0, imem_req}, 32'd0);
        check("t6.rst_pc", pc, 32'h0000_0000);
        check("t6.rst_count", instr_count, 32'd0);
        check("t6.rst_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        check("t6.late_ack_instr", instr, 32'd0);
        check("t6.late_ack_valid", {31'd0, instr_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        // Ack still high on the IDLE edge must not capture.
        check("t6.idle_instr", instr, 32'd0);
        check("t6.idle_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack  = 1'b0;
        exp_count = 32'd0;
        do_fetch("t6b", 32'h0000_0000, 32'h2008_0005, 0);
        do_release("t6b", 1'b0, 1'b0, 26'd0, 32'd0, 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
